pl_mem_arbiter: RTL and testbench
=================================

Name: pl_mem_arbiter

Overview:
- Arbitrates one single-port unified instruction/data memory between the fetch stage (F) and the memory stage (M) of the 5-stage RISC-V pipeline.
- Sequences each access with a req/ack handshake toward the memory.
- Produces stall requests that are ORed into the hazard unit's StallF and stall-M paths.
- Data port has fixed priority; an anti-starvation counter guarantees fetch progress.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_STARVE, 4, consecutive D grants while if_req is pending before F is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
if_req  in  1  fetch request, level, held until if_ready
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched instruction, valid when if_ready=1
if_ready  out  1  fetch access complete (1-cycle pulse)
d_req  in  1  data request, level, held until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid when d_ready=1
d_ready  out  1  data access complete (1-cycle pulse)
mem_en  out  1  memory request, held high until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address (registered)
mem_wdata  out  DW  memory write data (registered)
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completes the current access
stall_f  out  1  if_req & ~if_ready
stall_m  out  1  d_req & ~d_ready

Behaviour:
- States: IDLE, BUSY_F, BUSY_D. Reset state is IDLE.
- Reset (rst=0, any cycle, including mid-access):
  - State goes to IDLE; starve_cnt=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - The in-flight memory access is abandoned; no ready pulse is issued.
- Grant in IDLE:
  - If d_req=1 and not (if_req=1 and starve_cnt==MAX_STARVE): go to BUSY_D. Latch mem_addr=d_addr, mem_we=d_we, mem_wdata=d_wdata.
  - Else if if_req=1: go to BUSY_F. Latch mem_addr=if_addr, mem_we=0.
  - Else stay in IDLE.
- mem_en is registered: it is 1 in the BUSY states and 0 in IDLE.
- Address, data and write enable are stable for the whole BUSY period.
- In BUSY_x with mem_ack=1:
  - x_ready=1 combinationally in the same cycle.
  - x_rdata = mem_rdata (d_rdata is don't-care on a store).
  - Next state is IDLE.
- mem_ack seen in IDLE is ignored.
- Minimum access: request at cycle N, mem_en at N+1, earliest ready at N+1, next grant decision at N+2.
- Outside the matching BUSY state with ack, if_ready and d_ready are 0; if_rdata and d_rdata are 0.
- starve_cnt (4 bit):
  - +1 on each D grant while if_req=1, saturating at MAX_STARVE.
  - Cleared on every F grant.
  - Unchanged when D is granted with if_req=0.
- Requesters must hold req, addr and wdata until ready. A req dropped before grant is simply not served. A req dropped during BUSY does not cancel the memory access; the ready pulse is still issued.
- Simultaneous if_req and d_req in IDLE: D wins unless starvation forces F.
- stall_f and stall_m are purely combinational from the req and ready signals.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, three extra outputs exist: perf_f_cnt[31:0], perf_d_cnt[31:0], perf_stall_cnt[31:0].
  - perf_f_cnt and perf_d_cnt: +1 on each if_ready / d_ready pulse.
  - perf_stall_cnt: +1 each cycle where stall_f or stall_m is 1.
  - All wrap at 2^32 and clear on reset.
- When undefined, the ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x10, memory acks 1 cycle after mem_en with 0x00500093 -> mem_addr=0x10, mem_we=0; if_ready pulses with if_rdata=0x00500093; stall_f=1 only before ready.
- Store then load: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, then a load from 0x100 -> mem_we=1 with wdata=0xDEADBEEF on the first access; the second access has mem_we=0 and d_rdata equals the returned word.
- Contention: if_req and d_req held together with MAX_STARVE=4 -> grant order D,D,D,D,F,D,... ; starve_cnt clears after the F grant.
- Slow memory: mem_ack delayed 5 cycles -> mem_en, mem_addr and mem_wdata hold constant for 5 cycles; stall_m=1 throughout; exactly one d_ready pulse.
- Reset mid-access: rst=0 during BUSY_D -> all outputs 0 immediately (asynchronous); no ready pulse; after rst=1 a pending if_req is granted normally.
- With ARB_PERF_CNT_EN defined: 3 fetches and 2 data accesses -> perf_f_cnt=3, perf_d_cnt=2; perf_stall_cnt equals the cycle count in which stall_f or stall_m was high.

Source files
------------

// File: rtl/pl_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// pl_mem_arbiter_if
// Bundles the fetch port, the data port, the memory port and the two stall
// requests of the unified-memory arbiter.
//   master : arbiter side (drives ready/rdata, mem_* request side, stalls)
//   slave  : environment side (requesters and the memory)
// Signals:
//   if_req/if_addr -> if_rdata/if_ready          fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready data port
//   mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ack  memory port
//   stall_f/stall_m                               stall requests to hazard unit
// -----------------------------------------------------------------------------
interface pl_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          stall_f;
  logic          stall_m;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/pl_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pl_mem_arbiter
// Shares one single-port unified instruction/data memory between the fetch
// stage (F) and the memory stage (M). The data port has fixed priority; a
// starvation counter forces a fetch grant after MAX_STARVE consecutive data
// grants taken while a fetch was waiting.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   bus.master  fetch port, data port, memory port and stall requests
//               (see pl_mem_arbiter_if)
//   perf_*_cnt  performance counters, present only with ARB_PERF_CNT_EN
//
// Build option: define ARB_PERF_CNT_EN to add perf_f_cnt, perf_d_cnt and
// perf_stall_cnt (completed fetches, completed data accesses, stall cycles).
// -----------------------------------------------------------------------------
module pl_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic               clk,
  input  logic               rst,
  pl_mem_arbiter_if.master   bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_f_cnt,
  output logic [31:0]        perf_d_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  state_t        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          mem_en_q;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          force_f;

  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    return (cnt >= STARVE_MAX) ? STARVE_MAX : cnt + 4'd1;
  endfunction

  // A waiting fetch that has already lost MAX_STARVE times overrides D priority.
  assign force_f = bus.if_req && (starve_q == STARVE_MAX);

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    bus.if_ready  = 1'b0;
    bus.d_ready   = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rdata   = '0;

    case (state_q)
      IDLE: begin
        if (bus.d_req && !force_f) begin
          state_d     = BUSY_D;
          mem_addr_d  = bus.d_addr;
          mem_we_d    = bus.d_we;
          mem_wdata_d = bus.d_wdata;
          if (bus.if_req) begin
            starve_d = starve_inc(starve_q);
          end
        end else if (bus.if_req) begin
          state_d    = BUSY_F;
          mem_addr_d = bus.if_addr;
          mem_we_d   = 1'b0;
          starve_d   = 4'd0;
        end
      end
      BUSY_F: begin
        if (bus.mem_ack) begin
          bus.if_ready = 1'b1;
          bus.if_rdata = bus.mem_rdata;
          state_d      = IDLE;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          bus.d_ready = 1'b1;
          bus.d_rdata = bus.mem_rdata;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address, data and write enable only load on a grant, so they stay frozen
  // for the whole BUSY period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_en_q    <= (state_d != IDLE);
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.stall_f = bus.if_req & ~bus.if_ready;
  assign bus.stall_m = bus.d_req & ~bus.d_ready;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_f_q, perf_d_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_f_q     <= 32'd0;
      perf_d_q     <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (bus.if_ready) begin
        perf_f_q <= perf_f_q + 32'd1;
      end
      if (bus.d_ready) begin
        perf_d_q <= perf_d_q + 32'd1;
      end
      if (bus.stall_f || bus.stall_m) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_f_cnt     = perf_f_q;
  assign perf_d_cnt     = perf_d_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_pl_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pl_mem_arbiter
// Directed bench for pl_mem_arbiter with a small memory model whose ack
// latency is programmable, and scoreboards of expected grants and ready pulses.
// -----------------------------------------------------------------------------
module tb_pl_mem_arbiter;

  logic clk;
  logic rst;

  pl_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_f_cnt, perf_d_cnt, perf_stall_cnt;
`endif

  pl_mem_arbiter #(.AW(32), .DW(32), .MAX_STARVE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_f_cnt     (perf_f_cnt),
    .perf_d_cnt     (perf_d_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [256];
  int          lat;
  int          wait_cnt;

  assign bus.mem_ack   = bus.mem_en && (wait_cnt == lat);
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (!bus.mem_en || bus.mem_ack) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
    if (rst && bus.mem_en && bus.mem_ack && bus.mem_we)
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  // ---------------- scoreboards ----------------
  typedef struct { bit is_d; logic [31:0] rd; bit chk; } rdy_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wd; bit chk_wd; } gnt_t;
  rdy_t rdy_q[$];
  gnt_t gnt_q[$];

  int tests = 0;
  int fails = 0;
  int exp_f = 0, exp_d = 0, exp_stall = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  rdy_t re;
  gnt_t ge;
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.if_ready || bus.d_ready) begin
        if (rdy_q.size() == 0) begin
          check("unexpected_ready", {bus.d_ready, bus.if_ready}, 2'b00);
        end else begin
          re = rdy_q.pop_front();
          check("ready_port", {bus.d_ready, bus.if_ready}, re.is_d ? 2'b10 : 2'b01);
          if (re.chk) check("ready_rdata", re.is_d ? bus.d_rdata : bus.if_rdata, re.rd);
        end
      end
      if (bus.mem_en && !en_prev) begin
        if (gnt_q.size() == 0) begin
          check("unexpected_grant", bus.mem_addr, 32'hFFFF_FFFF);
        end else begin
          ge = gnt_q.pop_front();
          check("grant_addr", bus.mem_addr, ge.addr);
          check("grant_we", bus.mem_we, ge.we);
          if (ge.chk_wd) check("grant_wdata", bus.mem_wdata, ge.wd);
        end
      end
    end
    en_prev = bus.mem_en;
  end

  // One access from a single requester; ready expected lat_cfg+2 negedges
  // after the request is driven (one IDLE cycle, then lat_cfg+1 BUSY cycles).
  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input int lat_cfg, input bit skip_drive);
    int n;
    bit got;
    gnt_t g;
    rdy_t r;
    lat = lat_cfg;
    g.we = we; g.addr = addr; g.wd = wdata; g.chk_wd = is_d;
    gnt_q.push_back(g);
    r.is_d = is_d; r.rd = exp_rd; r.chk = !(is_d && we);
    rdy_q.push_back(r);
    exp_stall += lat_cfg + 1;
    if (is_d) exp_d++; else exp_f++;
    if (!skip_drive) begin
      @(posedge clk); #1;
      if (is_d) begin
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
      end else begin
        bus.if_req = 1'b1; bus.if_addr = addr;
      end
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = is_d ? bus.d_ready : bus.if_ready;
      check("stall_active", is_d ? bus.stall_m : bus.stall_f, !got);
      check("mem_en", bus.mem_en, n >= 2);
      if (n >= 2) begin
        check("mem_addr_hold", bus.mem_addr, addr);
        check("mem_we_hold", bus.mem_we, we);
        if (is_d) check("mem_wdata_hold", bus.mem_wdata, wdata);
        if (!got) check("rdata_idle", is_d ? bus.d_rdata : bus.if_rdata, 32'h0);
      end
    end
    check("latency", n, lat_cfg + 2);
    @(posedge clk); #1;
    if (is_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
    @(negedge clk);
    check("stall_after", {bus.stall_m, bus.stall_f}, 2'b00);
    check("mem_en_after", bus.mem_en, 1'b0);
  endtask

  gnt_t cg;
  rdy_t cr;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'h0050_0093;   // 0x010
    mem[8'h08] = 32'h3333_4444;   // 0x020
    mem[8'h80] = 32'h1111_2222;   // 0x200
    mem[8'hC0] = 32'h7777_7777;   // 0x300
    lat = 0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_ready", {bus.d_ready, bus.if_ready}, 2'b00);
    check("rst_stall", {bus.stall_m, bus.stall_f}, 2'b00);
    @(posedge clk); #1 rst = 1'b1;

    // Lone fetch, memory acks one cycle after mem_en
    access(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0093, 1, 1'b0);

    // Store then load of the same word
    access(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);

    // Slow memory store, then read it back
    access(1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 32'h0, 5, 1'b0);
    access(1'b1, 1'b0, 32'h104, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

    // Contention: both held, expected grant order D,D,D,D,F,D,D,D,D,F
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        cg.we = 1'b0; cg.addr = 32'h20; cg.wd = 32'h0; cg.chk_wd = 1'b0;
        cr.is_d = 1'b0; cr.rd = 32'h3333_4444; cr.chk = 1'b1;
      end else begin
        cg.we = 1'b0; cg.addr = 32'h200; cg.wd = 32'h0; cg.chk_wd = 1'b1;
        cr.is_d = 1'b1; cr.rd = 32'h1111_2222; cr.chk = 1'b1;
      end
      gnt_q.push_back(cg);
      rdy_q.push_back(cr);
    end
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_wdata = 32'h0;
    for (int i = 0; i < 100 && rdy_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check("contention_done", rdy_q.size(), 0);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    check("contention_grants_left", gnt_q.size(), 0);

    // Reset in the middle of a data access
    lat = 20;
    cg.we = 1'b1; cg.addr = 32'h300; cg.wd = 32'h55AA_55AA; cg.chk_wd = 1'b1;
    gnt_q.push_back(cg);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300; bus.d_wdata = 32'h55AA_55AA;
    repeat (3) @(negedge clk);
    check("midrst_busy", bus.mem_en, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midrst_mem_en", bus.mem_en, 1'b0);
    check("midrst_mem_we", bus.mem_we, 1'b0);
    check("midrst_mem_addr", bus.mem_addr, 32'h0);
    check("midrst_mem_wdata", bus.mem_wdata, 32'h0);
    check("midrst_ready", {bus.d_ready, bus.if_ready}, 2'b00);
    check("midrst_d_rdata", bus.d_rdata, 32'h0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    exp_f = 0; exp_d = 0; exp_stall = 0;
    lat = 0;
    repeat (2) @(negedge clk);
    check("inrst_mem_en", bus.mem_en, 1'b0);
    check("inrst_ready", {bus.d_ready, bus.if_ready}, 2'b00);
    @(posedge clk); #1 rst = 1'b1;
    access(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0093, 0, 1'b1);

    // Further traffic after reset: 3 fetches and 2 data accesses in total
    access(1'b0, 1'b0, 32'h20, 32'h0, 32'h3333_4444, 1, 1'b0);
    access(1'b1, 1'b0, 32'h200, 32'h0, 32'h1111_2222, 0, 1'b0);
    access(1'b1, 1'b1, 32'h208, 32'h0BAD_F00D, 32'h0, 2, 1'b0);
    access(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0093, 0, 1'b0);

    repeat (2) @(negedge clk);
    check("grant_queue_empty", gnt_q.size(), 0);
    check("ready_queue_empty", rdy_q.size(), 0);
`ifdef ARB_PERF_CNT_EN
    check("perf_f_cnt", perf_f_cnt, exp_f);
    check("perf_d_cnt", perf_d_cnt, exp_d);
    check("perf_stall_cnt", perf_stall_cnt, exp_stall);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
